// File: rtl/ifu_if.sv
// Instruction-fetch bus: imem request/response plus the decode-stage handoff.
interface ifu_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            fetch_fault;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, pc, fetch_fault,
    input  inst_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, pc, fetch_fault,
    output inst_ready
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: issues one word fetch at a time, buffers the returned
// word for decode, then waits for the next PC from execute.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_if.master       bus,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  input  logic        halt,
  output logic [31:0] fetch_count
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_OUT    = 3'd2,
    S_NEXT   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] inst_buf;
  logic            fault_q;
  logic [XLEN-1:0] pend_pc;
  logic            pend_valid;
  logic            halt_seen;
  logic [XLEN-1:0] count;
  logic            aligned;
  logic            halting;

  // A misaligned PC never reaches memory; a halt request is remembered until reset.
  assign aligned = (pc_reg[1:0] == 2'b00);
  assign halting = halt | halt_seen;

  // Outputs decode straight from registered state; gated so nothing is offered in reset.
  assign bus.imem_req_valid = rst_n && (state == S_REQ) && aligned;
  assign bus.imem_req_addr  = pc_reg;
  assign bus.inst_valid     = rst_n && (state == S_OUT);
  assign bus.inst           = inst_buf;
  assign bus.pc             = pc_reg;
  assign bus.fetch_fault    = fault_q;
  assign fetch_count        = count;

  // Fetch sequencer, PC, pending next-PC slot and instruction buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc_reg     <= RESET_PC;
      inst_buf   <= '0;
      fault_q    <= 1'b0;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      halt_seen  <= 1'b0;
      count      <= '0;
    end else begin
      if (halt) halt_seen <= 1'b1;

      case (state)
        S_REQ: begin
          if (!aligned) begin
            if (halting) begin
              state <= S_HALTED;
            end else begin
              inst_buf <= NOP_INST;
              fault_q  <= 1'b1;
              state    <= S_OUT;
            end
          end else if (bus.imem_req_ready) begin
            state <= S_WAIT;
          end else if (halting) begin
            state <= S_HALTED;
          end
        end

        S_WAIT: begin
          if (npc_valid) begin
            pend_pc    <= npc;
            pend_valid <= 1'b1;
          end
          if (bus.imem_rsp_valid) begin
            if (halting) begin
              state <= S_HALTED;
            end else begin
              inst_buf <= bus.imem_rsp_err ? NOP_INST : bus.imem_rsp_data;
              fault_q  <= bus.imem_rsp_err;
              state    <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (bus.inst_ready) begin
            count      <= count + 32'd1;
            pend_valid <= 1'b0;
            if (halting) begin
              state <= S_HALTED;
            end else if (npc_valid) begin
              pc_reg <= npc;
              state  <= S_REQ;
            end else if (pend_valid) begin
              pc_reg <= pend_pc;
              state  <= S_REQ;
            end else begin
              state <= S_NEXT;
            end
          end else if (npc_valid) begin
            pend_pc    <= npc;
            pend_valid <= 1'b1;
          end
        end

        S_NEXT: begin
          if (halting) begin
            state <= S_HALTED;
          end else if (npc_valid) begin
            pc_reg     <= npc;
            pend_valid <= 1'b0;
            state      <= S_REQ;
          end else if (pend_valid) begin
            pc_reg     <= pend_pc;
            pend_valid <= 1'b0;
            state      <= S_REQ;
          end
        end

        S_HALTED: state <= S_HALTED;

        default: state <= S_REQ;
      endcase
    end
  end
endmodule
